// File: rtl/alpha_pkg.sv
// Shared types and width helpers for the alpha numerator/denominator producer.
package alpha_pkg;

    typedef enum logic [1:0] {
        ACCUMULATE,
        MULT,
        SUB,
        OUTPUT
    } state_t;

    // Width of a plain sample sum over one block.
    function automatic int sum_w(input int dw, input int bsl);
        return dw + bsl;
    endfunction

    // Width of a sum of sample products over one block.
    function automatic int prod_w(input int dw, input int bsl);
        return 2 * dw + bsl;
    endfunction

    function automatic int final_width(input int dw, input int bsl);
        return 2 * dw + 2 + bsl;
    endfunction

endpackage

// File: rtl/alpha_accumulator_output_reg.sv
// Single-entry valid/data holding register with its own handshake and a done flag
// that stays set from the transfer until the next load.
module axis_output_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_done
);

    logic             r_valid;
    logic             r_done;
    logic [WIDTH-1:0] r_data;
    logic             w_xfer;

    assign w_xfer = r_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_done  <= 1'b0;
            r_data  <= i_data;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
        end
    end

    // Done includes the transfer happening this cycle so both outputs may finish together.
    assign o_done  = r_done | w_xfer;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/alpha_accumulator.sv
// Accumulates per-block sums of x, xm, x*xm and xm^2 and emits the alpha
// numerator and denominator for each block of 2^BLOCK_SIZE_LOG joined samples.
module alpha_accumulator
    import alpha_pkg::*;
#(
    parameter int  DATA_WIDTH     = 16,
    parameter int  BLOCK_SIZE_LOG = 8,
    localparam int FINAL_WIDTH    = final_width(DATA_WIDTH, BLOCK_SIZE_LOG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  x_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [DATA_WIDTH-1:0]  xm_data,
    input  logic                   xm_valid,
    output logic                   xm_ready,
    output logic [FINAL_WIDTH-1:0] alphan_data,
    output logic                   alphan_valid,
    input  logic                   alphan_ready,
    output logic [FINAL_WIDTH-1:0] alphad_data,
    output logic                   alphad_valid,
    input  logic                   alphad_ready
);

    localparam int SUM_W  = sum_w(DATA_WIDTH, BLOCK_SIZE_LOG);
    localparam int PROD_W = prod_w(DATA_WIDTH, BLOCK_SIZE_LOG);
    localparam int MUL_W  = 2 * SUM_W;
    localparam int EXT_W  = FINAL_WIDTH - PROD_W;

    state_t                    r_state;
    logic [BLOCK_SIZE_LOG-1:0] r_count;
    logic [SUM_W-1:0]          r_sx;
    logic [SUM_W-1:0]          r_sm;
    logic [PROD_W-1:0]         r_sxm;
    logic [PROD_W-1:0]         r_smm;
    logic [MUL_W-1:0]          r_p;
    logic [MUL_W-1:0]          r_q;

    logic                      w_xfer;
    logic [SUM_W-1:0]          w_x_sum;
    logic [SUM_W-1:0]          w_xm_sum;
    logic [PROD_W-1:0]         w_x_prod;
    logic [PROD_W-1:0]         w_xm_prod;
    logic [PROD_W-1:0]         w_x_xm;
    logic [PROD_W-1:0]         w_xm_xm;
    logic [MUL_W-1:0]          w_sx_mul;
    logic [MUL_W-1:0]          w_sm_mul;
    logic [PROD_W-1:0]         w_p_shift;
    logic [PROD_W-1:0]         w_q_shift;
    logic [FINAL_WIDTH-1:0]    w_alphan;
    logic [FINAL_WIDTH-1:0]    w_alphad;
    logic                      w_load;
    logic                      w_n_done;
    logic                      w_d_done;
    logic                      w_unused_low;

    assign w_xfer   = !rst && (r_state == ACCUMULATE) && x_valid && xm_valid;
    assign x_ready  = w_xfer;
    assign xm_ready = w_xfer;

    // Sign-extend operands to each accumulator width; two's-complement sums and
    // products at that width are then exact.
    assign w_x_sum   = {{BLOCK_SIZE_LOG{x_data[DATA_WIDTH-1]}}, x_data};
    assign w_xm_sum  = {{BLOCK_SIZE_LOG{xm_data[DATA_WIDTH-1]}}, xm_data};
    assign w_x_prod  = {{(PROD_W-DATA_WIDTH){x_data[DATA_WIDTH-1]}}, x_data};
    assign w_xm_prod = {{(PROD_W-DATA_WIDTH){xm_data[DATA_WIDTH-1]}}, xm_data};
    assign w_x_xm    = w_x_prod * w_xm_prod;
    assign w_xm_xm   = w_xm_prod * w_xm_prod;

    assign w_sx_mul = {{(MUL_W-SUM_W){r_sx[SUM_W-1]}}, r_sx};
    assign w_sm_mul = {{(MUL_W-SUM_W){r_sm[SUM_W-1]}}, r_sm};

    // Dropping the low bits is the floor arithmetic shift; the kept bits hold
    // the shifted value exactly since its redundant sign bits are not needed.
    assign w_p_shift    = r_p[MUL_W-1:BLOCK_SIZE_LOG];
    assign w_q_shift    = r_q[MUL_W-1:BLOCK_SIZE_LOG];
    assign w_unused_low = ^{r_p[BLOCK_SIZE_LOG-1:0], r_q[BLOCK_SIZE_LOG-1:0]};

    assign w_alphan = {{EXT_W{r_sxm[PROD_W-1]}}, r_sxm}
                    - {{EXT_W{w_p_shift[PROD_W-1]}}, w_p_shift};
    assign w_alphad = {{EXT_W{r_smm[PROD_W-1]}}, r_smm}
                    - {{EXT_W{w_q_shift[PROD_W-1]}}, w_q_shift};

    assign w_load = (r_state == SUB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUMULATE;
            r_count <= '0;
            r_sx    <= '0;
            r_sm    <= '0;
            r_sxm   <= '0;
            r_smm   <= '0;
            r_p     <= '0;
            r_q     <= '0;
        end else begin
            case (r_state)
                ACCUMULATE: begin
                    if (w_xfer) begin
                        r_sx    <= r_sx + w_x_sum;
                        r_sm    <= r_sm + w_xm_sum;
                        r_sxm   <= r_sxm + w_x_xm;
                        r_smm   <= r_smm + w_xm_xm;
                        r_count <= r_count + 1'b1;
                        if (r_count == '1) begin
                            r_state <= MULT;
                        end
                    end
                end
                MULT: begin
                    r_p     <= w_sx_mul * w_sm_mul;
                    r_q     <= w_sm_mul * w_sm_mul;
                    r_state <= SUB;
                end
                SUB: begin
                    r_state <= OUTPUT;
                end
                OUTPUT: begin
                    if (w_n_done && w_d_done) begin
                        r_sx    <= '0;
                        r_sm    <= '0;
                        r_sxm   <= '0;
                        r_smm   <= '0;
                        r_state <= ACCUMULATE;
                    end
                end
                default: r_state <= ACCUMULATE;
            endcase
        end
    end

    axis_output_reg #(
        .WIDTH(FINAL_WIDTH)
    ) u_alphan (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_alphan),
        .o_data  (alphan_data),
        .o_valid (alphan_valid),
        .i_ready (alphan_ready),
        .o_done  (w_n_done)
    );

    axis_output_reg #(
        .WIDTH(FINAL_WIDTH)
    ) u_alphad (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_alphad),
        .o_data  (alphad_data),
        .o_valid (alphad_valid),
        .i_ready (alphad_ready),
        .o_done  (w_d_done)
    );

endmodule

// File: tb/tb_alpha_accumulator.sv
// Directed bench for alpha_accumulator with 4-sample blocks.
module tb_alpha_accumulator;

    localparam int DW  = 16;
    localparam int BSL = 2;
    localparam int FW  = 2 * DW + 2 + BSL;

    typedef struct packed {
        logic [3:0][DW-1:0] x;
        logic [3:0][DW-1:0] xm;
        logic [FW-1:0]      en;
        logic [FW-1:0]      ed;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] x_data = '0;
    logic          x_valid = 1'b0;
    logic          x_ready;
    logic [DW-1:0] xm_data = '0;
    logic          xm_valid = 1'b0;
    logic          xm_ready;
    logic [FW-1:0] alphan_data;
    logic          alphan_valid;
    logic          alphan_ready = 1'b1;
    logic [FW-1:0] alphad_data;
    logic          alphad_valid;
    logic          alphad_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int n_blocks = 0;
    int n_xfers = 0;
    int d_xfers = 0;

    vec_t vecs [5];

    alpha_accumulator #(
        .DATA_WIDTH     (DW),
        .BLOCK_SIZE_LOG (BSL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .x_data       (x_data),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .xm_data      (xm_data),
        .xm_valid     (xm_valid),
        .xm_ready     (xm_ready),
        .alphan_data  (alphan_data),
        .alphan_valid (alphan_valid),
        .alphan_ready (alphan_ready),
        .alphad_data  (alphad_data),
        .alphad_valid (alphad_valid),
        .alphad_ready (alphad_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && alphan_valid && alphan_ready) n_xfers <= n_xfers + 1;
        if (!rst && alphad_valid && alphad_ready) d_xfers <= d_xfers + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the sample.
    task automatic send_sample(input logic [DW-1:0] xv, input logic [DW-1:0] xmv, input int skew);
        int n;
        x_data   = xv;
        xm_data  = xmv;
        x_valid  = 1'b1;
        xm_valid = (skew == 0);
        for (int s = 0; s < skew; s++) begin
            @(negedge clk);
            check("skew_hold", {62'd0, x_ready, xm_ready}, 64'd0);
            @(posedge clk); #1;
        end
        xm_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(x_ready && xm_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready", {62'd0, x_ready, xm_ready}, 64'd3);
        @(posedge clk); #1;
        x_valid  = 1'b0;
        xm_valid = 1'b0;
    endtask

    task automatic run_block(input vec_t v, input int skew, input logic bp);
        if (bp) alphad_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_sample(v.x[i], v.xm[i], skew);
        @(negedge clk);
        check("lat_t1", {62'd0, alphan_valid, alphad_valid}, 64'd0);
        @(negedge clk);
        check("lat_t2", {62'd0, alphan_valid, alphad_valid}, 64'd0);
        @(negedge clk);
        check("valid_t2", {62'd0, alphan_valid, alphad_valid}, 64'd3);
        check("alphan", {28'd0, alphan_data}, {28'd0, v.en});
        check("alphad", {28'd0, alphad_data}, {28'd0, v.ed});
        $display("block %0d: alphan=%0d alphad=%0d", n_blocks,
                 $signed(alphan_data), $signed(alphad_data));
        n_blocks++;
        if (bp) begin
            x_data   = 16'd1;
            xm_data  = 16'd1;
            x_valid  = 1'b1;
            xm_valid = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (k == 0) check("bp_alphan_done", {63'd0, alphan_valid}, 64'd0);
                check("bp_in_blocked", {62'd0, x_ready, xm_ready}, 64'd0);
                check("bp_d_valid", {63'd0, alphad_valid}, 64'd1);
                check("bp_d_stable", {28'd0, alphad_data}, {28'd0, v.ed});
            end
            alphad_ready = 1'b1;
            @(negedge clk);
            check("bp_d_done", {63'd0, alphad_valid}, 64'd0);
            check("bp_in_open", {62'd0, x_ready, xm_ready}, 64'd3);
            x_valid  = 1'b0;
            xm_valid = 1'b0;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            check("out_cleared", {62'd0, alphan_valid, alphad_valid}, 64'd0);
        end
    endtask

    initial begin
        vecs[0] = '{x: {16'd4, 16'd3, 16'd2, 16'd1}, xm: {16'd4, 16'd3, 16'd2, 16'd1},
                    en: 36'd5, ed: 36'd5};
        vecs[1] = '{x: {16'd8, 16'd6, 16'd4, 16'd2}, xm: {16'd4, 16'd3, 16'd2, 16'd1},
                    en: 36'd10, ed: 36'd5};
        vecs[2] = '{x: {-16'sd4, -16'sd3, -16'sd2, -16'sd1}, xm: {16'd4, 16'd3, 16'd2, 16'd1},
                    en: -36'sd5, ed: 36'd5};
        vecs[3] = '{x: {16'd4, 16'd3, 16'd2, 16'd1}, xm: {16'd7, 16'd7, 16'd7, 16'd7},
                    en: 36'd0, ed: 36'd0};
        vecs[4] = vecs[0];

        // Reset state, with valid inputs that must not be accepted.
        x_valid  = 1'b1;
        xm_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {62'd0, x_ready, xm_ready}, 64'd0);
        check("rst_valid", {62'd0, alphan_valid, alphad_valid}, 64'd0);
        check("rst_n_data", {28'd0, alphan_data}, 64'd0);
        check("rst_d_data", {28'd0, alphad_data}, 64'd0);
        x_valid  = 1'b0;
        xm_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;

        // Table blocks back to back; the last one proves the accumulators cleared.
        for (int i = 0; i < 5; i++) run_block(vecs[i], 0, 1'b0);

        // Skewed xm_valid.
        run_block(vecs[0], 3, 1'b0);

        // alphad backpressure, then the next block must still be accepted.
        run_block(vecs[0], 0, 1'b1);
        run_block(vecs[1], 0, 1'b0);

        // Reset after two samples discards the partial block.
        send_sample(16'd5, 16'd9, 0);
        send_sample(16'd6, 16'd3, 0);
        rst      = 1'b1;
        x_valid  = 1'b1;
        xm_valid = 1'b1;
        @(negedge clk);
        check("midrst_ready", {62'd0, x_ready, xm_ready}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst      = 1'b0;
        x_valid  = 1'b0;
        xm_valid = 1'b0;
        @(negedge clk);
        check("midrst_no_stale", {62'd0, alphan_valid, alphad_valid}, 64'd0);
        @(posedge clk); #1;
        run_block(vecs[0], 0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("alphan_xfer_count", 64'(n_xfers), 64'(n_blocks));
        check("alphad_xfer_count", 64'(d_xfers), 64'(n_blocks));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
